// File: rtl/message_loader.sv
// message_loader: assembles an ASCII byte stream into a double-buffered scroll
// message. Bytes fill the shadow bank; a carriage return swaps banks so the
// scroller only ever reads complete messages from the active bank.
//
// Ports:
//   clk, rst    - system clock, asynchronous active-high reset
//   in_valid    - input byte valid
//   in_data     - ASCII input byte
//   in_ready    - loader accepts a byte this cycle (low only while committing)
//   rd_idx      - character index requested by the scroller
//   rd_char     - registered character from the active bank (1-cycle latency)
//   msg_len     - length of the active message
//   msg_update  - one-cycle pulse when a new message becomes active
//   overflow    - sticky: a printable byte was dropped on a full shadow bank
module message_loader #(
  parameter int unsigned MSG_LEN    = 11,
  parameter int unsigned CHAR_WIDTH = 8,
  parameter int unsigned IDX_W      = $clog2(MSG_LEN),
  parameter int unsigned LEN_W      = $clog2(MSG_LEN + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [CHAR_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [CHAR_WIDTH-1:0] rd_char,
  output logic [LEN_W-1:0]      msg_len,
  output logic                  msg_update,
  output logic                  overflow
);

  localparam logic [LEN_W-1:0]      MSG_LEN_L = LEN_W'(MSG_LEN);
  localparam logic [CHAR_WIDTH-1:0] CH_SPACE  = CHAR_WIDTH'(8'h20);
  localparam logic [CHAR_WIDTH-1:0] CH_TILDE  = CHAR_WIDTH'(8'h7E);
  localparam logic [CHAR_WIDTH-1:0] CH_LO_A   = CHAR_WIDTH'(8'h61);
  localparam logic [CHAR_WIDTH-1:0] CH_LO_Z   = CHAR_WIDTH'(8'h7A);
  localparam logic [CHAR_WIDTH-1:0] CH_CASE   = CHAR_WIDTH'(8'h20);
  localparam logic [CHAR_WIDTH-1:0] CH_BS     = CHAR_WIDTH'(8'h08);
  localparam logic [CHAR_WIDTH-1:0] CH_CR     = CHAR_WIDTH'(8'h0D);
  localparam logic [CHAR_WIDTH-1:0] CH_ESC    = CHAR_WIDTH'(8'h1B);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [LEN_W-1:0]        count;
  logic [LEN_W-1:0]        count_nxt;
  logic                    ovf_nxt;
  logic                    bank_sel;
  logic                    wr_en;
  logic                    commit;
  logic [CHAR_WIDTH-1:0]   wr_data;
  logic [CHAR_WIDTH-1:0]   rd_char_nxt;

  // Two banks; bank_sel names the active one, the other is the shadow.
  logic [CHAR_WIDTH-1:0] bank [2][MSG_LEN];

  // Byte classification of the incoming character
  logic accept;
  logic is_print;
  logic is_lower;
  logic is_bs;
  logic is_cr;
  logic is_esc;

  always_comb begin
    accept   = in_valid && in_ready;
    is_print = (in_data >= CH_SPACE) && (in_data <= CH_TILDE);
    is_lower = (in_data >= CH_LO_A) && (in_data <= CH_LO_Z);
    is_bs    = (in_data == CH_BS);
    is_cr    = (in_data == CH_CR);
    is_esc   = (in_data == CH_ESC);
    wr_data  = is_lower ? (in_data - CH_CASE) : in_data;
  end

  // State register and loader bookkeeping
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      overflow   <= 1'b0;
      bank_sel   <= 1'b0;
      msg_len    <= '0;
      msg_update <= 1'b0;
      in_ready   <= 1'b1;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      overflow   <= ovf_nxt;
      msg_update <= commit;
      in_ready   <= (state_nxt != COMMIT);
      if (commit) begin
        bank_sel <= ~bank_sel;
        msg_len  <= count;
      end
    end
  end

  // Next-state and control decode
  always_comb begin
    state_nxt = state;
    count_nxt = count;
    ovf_nxt   = overflow;
    wr_en     = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE, RECV: begin
        if (accept) begin
          if (is_print) begin
            if (count < MSG_LEN_L) begin
              wr_en     = 1'b1;
              count_nxt = count + LEN_W'(1);
              state_nxt = RECV;
            end else begin
              ovf_nxt = 1'b1;
            end
          end else if (is_bs) begin
            // Stored byte is left in place; only the length shrinks.
            if (count != '0) begin
              count_nxt = count - LEN_W'(1);
              if (count == LEN_W'(1)) begin
                state_nxt = IDLE;
              end
            end
          end else if (is_cr) begin
            // An empty line keeps the current active message.
            if (count != '0) begin
              state_nxt = COMMIT;
            end
          end else if (is_esc) begin
            count_nxt = '0;
            ovf_nxt   = 1'b0;
            state_nxt = IDLE;
          end
        end
      end
      COMMIT: begin
        commit    = 1'b1;
        count_nxt = '0;
        ovf_nxt   = 1'b0;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shadow bank write; bank storage carries no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      bank[~bank_sel][IDX_W'(count)] <= wr_data;
    end
  end

  // Read from the pre-edge active bank; out-of-message indices read as space.
  always_comb begin
    rd_char_nxt = CH_SPACE;
    if (LEN_W'(rd_idx) < msg_len) begin
      rd_char_nxt = bank[bank_sel][rd_idx];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_char <= CH_SPACE;
    end else begin
      rd_char <= rd_char_nxt;
    end
  end

endmodule
